fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: PC loaded on reset and on start.
REQ-002 SHALL have parameter PC_LIMIT, default 16'd56: highest legal fetch address, inclusive.
REQ-003 SHALL have parameter HALT_WORD, default 16'hEFFF: instruction word that stops fetching.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port start, input, 1: one-cycle pulse that leaves IDLE or HALT and begins fetching at RESET_PC.
REQ-007 SHALL have port pc_out, output, 16: fetch address to the instruction memory.
REQ-008 SHALL have port imem_instr, input, 16: memory data, valid one cycle after pc_out is presented.
REQ-009 SHALL have port instr_out, output, 16: registered instruction for decode.
REQ-010 SHALL have port instr_valid, output, 1: instr_out holds an undelivered instruction.
REQ-011 SHALL have port instr_ready, input, 1: decode accepts instr_out.
REQ-012 SHALL have port br_taken, input, 1: redirect request from decode.
REQ-013 SHALL have port br_target, input, 16: redirect address.
REQ-014 SHALL have port halted, output, 1: HALT state.
REQ-015 SHALL have port pc_err, output, 1: halt caused by a PC above PC_LIMIT.
REQ-016 SHALL have port fetch_count, output, 16: number of delivered instructions.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, CAPTURE, HOLD and HALT.
REQ-018 IDLE: on start, pc <= RESET_PC and go to ISSUE; all other inputs are ignored.
REQ-019 ISSUE: pc_out = pc; go to CAPTURE next cycle.
REQ-020 CAPTURE: if imem_instr == HALT_WORD, go to HALT without asserting instr_valid; otherwise instr_out <= imem_instr, instr_valid <= 1, go to HOLD.
REQ-021 HOLD: instr_valid and instr_out SHALL stay stable until instr_valid && instr_ready; on that handshake, instr_valid <= 0, pc <= pc+2, fetch_count increments, go to ISSUE.
REQ-022 Throughput SHALL be at most one instruction per 3 cycles: ISSUE, CAPTURE, and HOLD with instr_ready high.
REQ-023 br_taken in ISSUE, CAPTURE or HOLD SHALL discard any in-flight or held instruction, set instr_valid <= 0, set pc <= {br_target[15:1],1'b0} and go to ISSUE next cycle.
REQ-024 br_taken coincident with a HOLD handshake SHALL count the handshake in fetch_count and take the branch target, not pc+2.
REQ-025 br_taken SHALL be ignored in IDLE and HALT.
REQ-026 Before any ISSUE, if pc > PC_LIMIT (from increment or branch), go to HALT with pc_err <= 1 instead; no memory access SHALL occur.
REQ-027 pc+2 SHALL wrap modulo 2^16; the PC_LIMIT check still applies after wrap.
REQ-028 fetch_count SHALL saturate at 16'hFFFF.
REQ-029 HALT: halted = 1 and instr_valid = 0; start SHALL clear halted and pc_err, reload RESET_PC, keep fetch_count and go to ISSUE.
REQ-030 pc_out SHALL equal the registered pc in every state, not only in ISSUE.

Reset
REQ-031 When rst = 0 at a rising edge: state <= IDLE, pc_out <= RESET_PC, instr_out <= 0, instr_valid <= 0, halted <= 0, pc_err <= 0, fetch_count <= 0.
REQ-032 Reset SHALL override every other input, including start, br_taken and handshakes, in the same cycle.
REQ-033 Reset in any state, including mid-HOLD, SHALL drop the held instruction without counting it.

Verification
REQ-034 Test straight-line fetch: memory 0:F120, 2:F121, 4:EFFF, start, instr_ready = 1 → instr_out F120 then F121, halted = 1, fetch_count = 2, pc_err = 0.
REQ-035 Test backpressure: instr_ready = 0 for 5 cycles in HOLD → instr_valid and instr_out stay stable and pc_out stays 0; on ready, pc_out = 2.
REQ-036 Test branch: br_taken = 1 with br_target = 16'h0019 during CAPTURE of address 2 → no valid for address 2, next pc_out = 16'h0018.
REQ-037 Test limit: PC_LIMIT = 4, no halt word → after delivering 0, 2 and 4, halted = 1, pc_err = 1, pc_out = 6, no access to 6.
REQ-038 Test reset mid-HOLD: rst = 0 for one cycle while instr_valid = 1 → next cycle IDLE, instr_valid = 0, fetch_count = 0, pc_out = RESET_PC.
REQ-039 Test restart: start during HALT with fetch_count = 2 → halted = 0, pc_out = RESET_PC, fetch_count remains 2.

Source files
------------

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer: single-issue fetch FSM with decode handshake and redirect
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_sequencer #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] PC_LIMIT  = 16'd56,
  parameter logic [15:0] HALT_WORD = 16'hEFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [15:0] pc_out,
  input  logic [15:0] imem_instr,
  output logic [15:0] instr_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic        halted,
  output logic        pc_err,
  output logic [15:0] fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_HOLD    = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_instr;
  logic        r_valid;
  logic        r_halted;
  logic        r_pc_err;
  logic [15:0] r_count;

  state_t      w_state;
  logic [15:0] w_pc;
  logic [15:0] w_instr;
  logic        w_valid;
  logic        w_halted;
  logic        w_pc_err;
  logic [15:0] w_count;

  logic        w_load;
  logic [15:0] w_target;
  logic [15:0] w_pc_inc;
  logic [15:0] w_br_pc;
  logic [15:0] w_count_inc;

  assign w_pc_inc    = r_pc + 16'd2;
  assign w_br_pc     = br_target & 16'hFFFE;
  assign w_count_inc = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;

  always_comb begin
    w_state  = r_state;
    w_pc     = r_pc;
    w_instr  = r_instr;
    w_valid  = r_valid;
    w_halted = r_halted;
    w_pc_err = r_pc_err;
    w_count  = r_count;
    w_load   = 1'b0;
    w_target = r_pc;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load   = 1'b1;
          w_target = RESET_PC;
        end
      end

      S_ISSUE: begin
        if (br_taken) begin
          w_load   = 1'b1;
          w_target = w_br_pc;
        end else begin
          w_state = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        if (br_taken) begin
          w_load   = 1'b1;
          w_target = w_br_pc;
        end else if (imem_instr == HALT_WORD) begin
          w_state  = S_HALT;
          w_halted = 1'b1;
        end else begin
          w_instr = imem_instr;
          w_valid = 1'b1;
          w_state = S_HOLD;
        end
      end

      S_HOLD: begin
        // A handshake coincident with a branch still counts as delivered
        if (r_valid && instr_ready) begin
          w_count = w_count_inc;
          w_valid = 1'b0;
        end
        if (br_taken) begin
          w_valid  = 1'b0;
          w_load   = 1'b1;
          w_target = w_br_pc;
        end else if (r_valid && instr_ready) begin
          w_load   = 1'b1;
          w_target = w_pc_inc;
        end
      end

      S_HALT: begin
        if (start) begin
          w_halted = 1'b0;
          w_pc_err = 1'b0;
          w_load   = 1'b1;
          w_target = RESET_PC;
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase

    // Every path into ISSUE is screened here so an illegal PC never reaches memory
    if (w_load) begin
      w_pc = w_target;
      if (w_target > PC_LIMIT) begin
        w_state  = S_HALT;
        w_halted = 1'b1;
        w_pc_err = 1'b1;
        w_valid  = 1'b0;
      end else begin
        w_state = S_ISSUE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_instr  <= 16'h0000;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_pc_err <= 1'b0;
      r_count  <= 16'h0000;
    end else begin
      r_state  <= w_state;
      r_pc     <= w_pc;
      r_instr  <= w_instr;
      r_valid  <= w_valid;
      r_halted <= w_halted;
      r_pc_err <= w_pc_err;
      r_count  <= w_count;
    end
  end

  assign pc_out      = r_pc;
  assign instr_out   = r_instr;
  assign instr_valid = r_valid;
  assign halted      = r_halted;
  assign pc_err      = r_pc_err;
  assign fetch_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer: directed self-checking bench for fetch_sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] pc_out;
  logic [15:0] imem_instr;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        br_taken;
  logic [15:0] br_target;
  logic        halted;
  logic        pc_err;
  logic [15:0] fetch_count;

  logic        start_l;
  logic [15:0] pc_l;
  logic [15:0] imem_l;
  logic [15:0] instr_l;
  logic        valid_l;
  logic        ready_l;
  logic        br_l;
  logic [15:0] br_target_l;
  logic        halted_l;
  logic        pc_err_l;
  logic [15:0] count_l;

  logic [15:0] mem [0:63];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pc_out      (pc_out),
    .imem_instr  (imem_instr),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .halted      (halted),
    .pc_err      (pc_err),
    .fetch_count (fetch_count)
  );

  fetch_sequencer #(.PC_LIMIT(16'd4)) dut_lim (
    .clk         (clk),
    .rst         (rst),
    .start       (start_l),
    .pc_out      (pc_l),
    .imem_instr  (imem_l),
    .instr_out   (instr_l),
    .instr_valid (valid_l),
    .instr_ready (ready_l),
    .br_taken    (br_l),
    .br_target   (br_target_l),
    .halted      (halted_l),
    .pc_err      (pc_err_l),
    .fetch_count (count_l)
  );

  // Synchronous memories: data for pc_out appears one cycle later
  always @(posedge clk) begin
    imem_instr <= mem[pc_out[6:1]];
    imem_l     <= 16'hA000 | pc_l;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[0]  = 16'hF120;
    mem[1]  = 16'hF121;
    mem[2]  = 16'hEFFF;
    mem[12] = 16'h1234;

    rst = 1'b0; start = 1'b0; instr_ready = 1'b0; br_taken = 1'b0; br_target = 16'h0000;
    start_l = 1'b0; ready_l = 1'b1; br_l = 1'b0; br_target_l = 16'h0000;
    step(); step();

    check("rst_pc",     pc_out, 16'h0000);
    check("rst_valid",  {15'd0, instr_valid}, 16'd0);
    check("rst_instr",  instr_out, 16'h0000);
    check("rst_halted", {15'd0, halted}, 16'd0);
    check("rst_pcerr",  {15'd0, pc_err}, 16'd0);
    check("rst_count",  fetch_count, 16'd0);

    // Straight-line fetch with backpressure on the first instruction
    rst = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    check("hold_valid", {15'd0, instr_valid}, 16'd1);
    check("hold_instr0", instr_out, 16'hF120);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", {15'd0, instr_valid}, 16'd1);
      check("bp_instr", instr_out, 16'hF120);
      check("bp_pc",    pc_out, 16'h0000);
    end
    instr_ready = 1'b1;
    step();
    check("ack_pc",    pc_out, 16'h0002);
    check("ack_valid", {15'd0, instr_valid}, 16'd0);
    check("ack_count", fetch_count, 16'd1);
    step(); step();
    check("instr1", instr_out, 16'hF121);
    check("valid1", {15'd0, instr_valid}, 16'd1);
    step(); step(); step();
    check("sl_halted", {15'd0, halted}, 16'd1);
    check("sl_count",  fetch_count, 16'd2);
    check("sl_pcerr",  {15'd0, pc_err}, 16'd0);
    check("sl_valid",  {15'd0, instr_valid}, 16'd0);

    // Restart from HALT keeps the delivered count
    start = 1'b1;
    step();
    start = 1'b0;
    check("rs_halted", {15'd0, halted}, 16'd0);
    check("rs_pc",     pc_out, 16'h0000);
    check("rs_count",  fetch_count, 16'd2);

    // Branch during CAPTURE of address 2
    step(); step();
    check("br_instr0", instr_out, 16'hF120);
    step();
    check("br_count3", fetch_count, 16'd3);
    step();
    br_taken = 1'b1; br_target = 16'h0019;
    step();
    br_taken = 1'b0;
    check("br_pc",    pc_out, 16'h0018);
    check("br_valid", {15'd0, instr_valid}, 16'd0);
    check("br_count", fetch_count, 16'd3);
    step(); step();
    check("br_tgt_valid", {15'd0, instr_valid}, 16'd1);
    check("br_tgt_instr", instr_out, 16'h1234);

    // Branch coincident with handshake: counted, and target wins over pc+2
    br_taken = 1'b1; br_target = 16'h0004;
    step();
    br_taken = 1'b0;
    check("bh_pc",    pc_out, 16'h0004);
    check("bh_count", fetch_count, 16'd4);
    check("bh_valid", {15'd0, instr_valid}, 16'd0);
    step(); step();
    check("bh_halted", {15'd0, halted}, 16'd1);

    // Branch ignored in HALT
    br_taken = 1'b1; br_target = 16'h0010;
    step();
    br_taken = 1'b0;
    check("hb_pc",     pc_out, 16'h0004);
    check("hb_halted", {15'd0, halted}, 16'd1);

    // Reset mid-HOLD overrides start, branch and handshake
    instr_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    check("mh_valid", {15'd0, instr_valid}, 16'd1);
    rst = 1'b0; start = 1'b1; instr_ready = 1'b1; br_taken = 1'b1; br_target = 16'h0010;
    step();
    rst = 1'b1; start = 1'b0; instr_ready = 1'b0; br_taken = 1'b0;
    check("mr_valid",  {15'd0, instr_valid}, 16'd0);
    check("mr_count",  fetch_count, 16'd0);
    check("mr_pc",     pc_out, 16'h0000);
    check("mr_halted", {15'd0, halted}, 16'd0);
    step(); step(); step();
    check("mr_idle_valid", {15'd0, instr_valid}, 16'd0);
    check("mr_idle_pc",    pc_out, 16'h0000);

    // Branch beyond PC_LIMIT halts with pc_err
    start = 1'b1;
    step();
    start = 1'b0;
    br_taken = 1'b1; br_target = 16'h0041;
    step();
    br_taken = 1'b0;
    check("bl_halted", {15'd0, halted}, 16'd1);
    check("bl_pcerr",  {15'd0, pc_err}, 16'd1);
    check("bl_pc",     pc_out, 16'h0040);
    check("bl_count",  fetch_count, 16'd0);

    // Limit instance: delivers 0, 2, 4 then stops at 6 without fetching it
    start_l = 1'b1;
    step();
    start_l = 1'b0;
    step(); step();
    check("lim_i0", instr_l, 16'hA000);
    step(); step(); step();
    check("lim_i2", instr_l, 16'hA002);
    step(); step(); step();
    check("lim_i4", instr_l, 16'hA004);
    check("lim_v4", {15'd0, valid_l}, 16'd1);
    step();
    check("lim_halted", {15'd0, halted_l}, 16'd1);
    check("lim_pcerr",  {15'd0, pc_err_l}, 16'd1);
    check("lim_pc",     pc_l, 16'h0006);
    check("lim_count",  count_l, 16'd3);
    step(); step(); step();
    check("lim_novalid", {15'd0, valid_l}, 16'd0);
    check("lim_instr",   instr_l, 16'hA004);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
